// File: rtl/inst_buffer_gen.sv
`default_nettype none
// ============================================================================
// Module   : inst_buffer_gen
// Brief    : Circular instruction buffer; compacts sparse fetch groups and
//            dispatches up to DISPATCH_W packets per cycle from the head.
// Revision : 1.0
// ============================================================================
module inst_buffer_gen #(
    parameter int DEPTH      = 32,
    parameter int FETCH_W    = 8,
    parameter int DISPATCH_W = 4,
    parameter int PKT_W      = 64,
    parameter int BR_BIT     = 63,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1,
    localparam int BC_W      = $clog2(DISPATCH_W + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          stall_i,
    input  logic                          partialEn_i,
    input  logic                          decodeReady_i,
    input  logic [FETCH_W-1:0]            decodedVector_i,
    input  logic [FETCH_W*PKT_W-1:0]      decodedPacket_i,
    output logic                          stallFetch_o,
    output logic [DISPATCH_W-1:0]         dispatchVector_o,
    output logic [DISPATCH_W*PKT_W-1:0]   dispatchPacket_o,
    output logic [BC_W-1:0]               branchCount_o,
    output logic [CNT_W-1:0]              count_o
);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] count;

    logic [PTR_W-1:0] wrOffset [FETCH_W];
    logic [CNT_W-1:0] nWr;
    logic [CNT_W-1:0] nRd;
    logic             wrEn;
    logic [CNT_W:0]   countNext;

    assign stallFetch_o = (count > CNT_W'(DEPTH - FETCH_W));
    assign wrEn         = decodeReady_i && !stallFetch_o && !flush_i;
    assign count_o      = count;

    // Running popcount gives each valid lane its compacted slot past the tail.
    always_comb begin
        nWr = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            wrOffset[k] = nWr[PTR_W-1:0];
            nWr         = nWr + CNT_W'(decodedVector_i[k]);
        end
        if (!wrEn) begin
            nWr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (decodedVector_i[k]) begin
                    mem[tailPtr + wrOffset[k]] <= decodedPacket_i[k*PKT_W +: PKT_W];
                end
            end
        end
    end

    for (genvar k = 0; k < DISPATCH_W; k++) begin : g_lane
        logic [PTR_W-1:0] rdAddr;
        assign rdAddr = headPtr + PTR_W'(k);
        assign dispatchPacket_o[k*PKT_W +: PKT_W] = mem[rdAddr];
        assign dispatchVector_o[k] = partialEn_i ? (count > CNT_W'(k))
                                                 : (count >= CNT_W'(DISPATCH_W));
    end

    always_comb begin
        branchCount_o = '0;
        nRd           = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            branchCount_o = branchCount_o
                          + BC_W'(dispatchVector_o[k] & dispatchPacket_o[k*PKT_W + BR_BIT]);
            nRd           = nRd + CNT_W'(dispatchVector_o[k]);
        end
        if (stall_i || flush_i) begin
            nRd = '0;
        end
    end

    // Extra carry bit guards the add/subtract; a borrow can only mean empty.
    assign countNext = {1'b0, count} + {1'b0, nWr} - {1'b0, nRd};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (flush_i) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            headPtr <= headPtr + nRd[PTR_W-1:0];
            tailPtr <= tailPtr + nWr[PTR_W-1:0];
            count   <= countNext[CNT_W] ? '0 : countNext[CNT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_buffer_gen
// Brief    : Scoreboard bench for inst_buffer_gen with directed scenarios.
// Revision : 1.0
// ============================================================================
module tb_inst_buffer_gen;

    localparam int DEPTH      = 32;
    localparam int FETCH_W    = 8;
    localparam int DISPATCH_W = 4;
    localparam int PKT_W      = 64;
    localparam int BR_BIT     = 63;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush_i;
    logic         stall_i;
    logic         partialEn_i;
    logic         decodeReady_i;
    logic [7:0]   decodedVector_i;
    logic [511:0] decodedPacket_i;
    logic         stallFetch_o;
    logic [3:0]   dispatchVector_o;
    logic [255:0] dispatchPacket_o;
    logic [2:0]   branchCount_o;
    logic [5:0]   count_o;

    inst_buffer_gen #(
        .DEPTH      (DEPTH),
        .FETCH_W    (FETCH_W),
        .DISPATCH_W (DISPATCH_W),
        .PKT_W      (PKT_W),
        .BR_BIT     (BR_BIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_i          (flush_i),
        .stall_i          (stall_i),
        .partialEn_i      (partialEn_i),
        .decodeReady_i    (decodeReady_i),
        .decodedVector_i  (decodedVector_i),
        .decodedPacket_i  (decodedPacket_i),
        .stallFetch_o     (stallFetch_o),
        .dispatchVector_o (dispatchVector_o),
        .dispatchPacket_o (dispatchPacket_o),
        .branchCount_o    (branchCount_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        bit br;
    } ent_t;

    ent_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;
    int   mCount  = 0;
    int   grp     = 0;
    int   totalWr = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Monitor: every real dispatch pops the oldest expected entries in order.
    always @(negedge clk) begin
        int   nb;
        ent_t e;
        nb = 0;
        if (!reset && !flush_i && !stall_i && dispatchVector_o != 4'd0) begin
            for (int k = 0; k < DISPATCH_W; k++) begin
                if (dispatchVector_o[k]) begin
                    if (expQ.size() == 0) begin
                        chk("dispatch_with_empty_model", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        chk("lane_tag", longint'(dispatchPacket_o[k*PKT_W +: 32]), e.tag);
                        if (e.br) nb++;
                    end
                end
            end
            chk("branchCount", branchCount_o, nb);
        end
    end

    // Applies one cycle of inputs at posedge+1, checks the current state, advances the model.
    task automatic setIn(input bit dr, input logic [7:0] vec, input bit stall,
                         input bit part, input bit fl);
        int nWr;
        int nRd;
        int avail;
        int expV;
        decodeReady_i   = dr;
        decodedVector_i = vec;
        stall_i         = stall;
        partialEn_i     = part;
        flush_i         = fl;
        for (int k = 0; k < FETCH_W; k++) begin
            if (vec[k])
                decodedPacket_i[k*PKT_W +: PKT_W] = {((grp + k) % 3 == 0), 31'd0, 32'(grp*16 + k)};
            else
                decodedPacket_i[k*PKT_W +: PKT_W] = {1'b1, 31'd0, 32'hDEAD};
        end
        avail = (mCount < 4) ? mCount : 4;
        expV  = part ? ((1 << avail) - 1) : ((mCount >= 4) ? 15 : 0);
        nRd   = (stall || fl) ? 0 : (part ? avail : ((mCount >= 4) ? 4 : 0));
        #1;
        chk("count_o", count_o, mCount);
        chk("stallFetch_o", stallFetch_o, (mCount > 24) ? 1 : 0);
        chk("dispatchVector_o", dispatchVector_o, expV);
        nWr = 0;
        if (dr && mCount <= 24 && !fl) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (vec[k]) begin
                    expQ.push_back('{grp*16 + k, ((grp + k) % 3 == 0)});
                    nWr++;
                end
            end
            grp++;
        end
        totalWr += nWr;
        if (fl) begin
            expQ.delete();
            mCount = 0;
        end else begin
            mCount = mCount + nWr - nRd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit part);
        for (int i = 0; i < 40; i++) begin
            if (mCount == 0) break;
            setIn(1'b0, 8'h00, 1'b0, part, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat [6];
        pat[0] = 8'hFF; pat[1] = 8'h0F; pat[2] = 8'h81;
        pat[3] = 8'h3C; pat[4] = 8'h00; pat[5] = 8'hF0;

        reset = 1'b1; flush_i = 1'b0; stall_i = 1'b1; partialEn_i = 1'b0;
        decodeReady_i = 1'b0; decodedVector_i = '0; decodedPacket_i = '0;
        #2;
        chk("rst_count", count_o, 0);
        chk("rst_stallFetch", stallFetch_o, 0);
        chk("rst_vec", dispatchVector_o, 0);
        chk("rst_branch", branchCount_o, 0);
        #5 reset = 1'b0;
        @(posedge clk); #1;

        // Sparse write: lanes 0,2,5,7 compacted to the head in order
        setIn(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        chk("sparse_count", count_o, 4);
        chk("sparse_head0", longint'(dispatchPacket_o[0*64 +: 32]), 0);
        chk("sparse_head1", longint'(dispatchPacket_o[1*64 +: 32]), 2);
        chk("sparse_head2", longint'(dispatchPacket_o[2*64 +: 32]), 5);
        chk("sparse_head3", longint'(dispatchPacket_o[3*64 +: 32]), 7);
        chk("sparse_branch", branchCount_o, 1);
        setIn(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("sparse_drained", count_o, 0);

        // Full-only versus partial dispatch with three entries
        setIn(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
        chk("fullonly_vec", dispatchVector_o, 4'b0000);
        partialEn_i = 1'b1;
        #1;
        chk("partial_vec", dispatchVector_o, 4'b0111);
        setIn(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("partial_drained", count_o, 0);

        // Fill to the stall boundary, then try one more group
        for (int i = 0; i < 3; i++) setIn(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("fill_24", count_o, 24);
        chk("fill_24_nostall", stallFetch_o, 0);
        setIn(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("fill_32", count_o, 32);
        chk("fill_32_stall", stallFetch_o, 1);
        setIn(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("fill_dropped", count_o, 32);
        drain(1'b0);

        // Streaming across several wraps
        totalWr = 0;
        for (int i = 0; i < 200 && totalWr < 100; i++)
            setIn(1'b1, pat[i % 6], (i % 5 == 4), 1'b1, 1'b0);
        drain(1'b1);

        // Flush with a simultaneous fetch group
        setIn(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        setIn(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        setIn(1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
        chk("flush_pre_count", count_o, 17);
        setIn(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        chk("flush_count", count_o, 0);
        chk("flush_vec", dispatchVector_o, 0);
        setIn(1'b1, 8'h10, 1'b1, 1'b1, 1'b0);
        chk("flush_next_count", count_o, 1);
        drain(1'b1);

        // Asynchronous reset between edges with twelve queued entries
        setIn(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        setIn(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0);
        chk("areset_pre_count", count_o, 12);
        decodeReady_i = 1'b0;
        stall_i       = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("areset_count", count_o, 0);
        chk("areset_vec", dispatchVector_o, 0);
        chk("areset_branch", branchCount_o, 0);
        chk("areset_stallFetch", stallFetch_o, 0);
        expQ.delete();
        mCount = 0;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        setIn(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        chk("areset_after_count", count_o, 4);
        setIn(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("areset_after_drained", count_o, 0);

        @(posedge clk); #1;
        chk("scoreboard_empty", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_buffer_gen.md
INST_BUFFER_GEN -- requirements
Module: inst_buffer_gen

Interface
REQ-001 Parameters SHALL be as listed.
- DEPTH: default 32; entry count; power of two, at least 2*FETCH_W.
- FETCH_W: default 8; write lanes per cycle.
- DISPATCH_W: default 4; read lanes per cycle; at most FETCH_W.
- PKT_W: default 64; decoded-packet width in bits.
- BR_BIT: default 63; packet bit that flags a branch.
REQ-002 Derived widths SHALL be as listed.
- PTR_W = log2(DEPTH).
- CNT_W = PTR_W+1.
- BC_W = bits needed to hold DISPATCH_W.
REQ-003 Ports SHALL be as listed.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- flush_i  in  1  synchronous flush on misprediction.
- stall_i  in  1  downstream cannot accept a dispatch group.
- partialEn_i  in  1  mode select: 1 = partial dispatch allowed; 0 = full groups only.
- decodeReady_i  in  1  fetch group is present.
- decodedVector_i  in  FETCH_W  per-lane valid; may be sparse.
- decodedPacket_i  in  FETCH_W*PKT_W  lane k at bits [k*PKT_W +: PKT_W].
- stallFetch_o  out  1  buffer cannot guarantee room for a full fetch group.
- dispatchVector_o  out  DISPATCH_W  per-lane valid of the head group.
- dispatchPacket_o  out  DISPATCH_W*PKT_W  packets at head, head+1, and so on.
- branchCount_o  out  BC_W  number of valid dispatch lanes whose BR_BIT is set.
- count_o  out  CNT_W  current occupancy.

Function
REQ-004 Storage SHALL be a circular queue of DEPTH entries with PTR_W-bit headPtr and tailPtr that wrap modulo DEPTH, plus a CNT_W-bit count register.
REQ-005 stallFetch_o SHALL equal (count > DEPTH-FETCH_W), computed only from registered count.
REQ-006 A fetch group SHALL be accepted when decodeReady_i=1 and stallFetch_o=0; otherwise the group is dropped and nothing is written.
REQ-007 Accepted valid lanes SHALL be compacted in ascending lane order: the j-th set bit of decodedVector_i writes to tailPtr+j mod DEPTH.
REQ-008 When a group is accepted, tailPtr SHALL advance by nWr, the popcount of decodedVector_i; otherwise nWr=0.
REQ-009 When partialEn_i=0, dispatchVector_o SHALL be all ones if count>=DISPATCH_W, and all zeros otherwise.
REQ-010 When partialEn_i=1, dispatchVector_o[k] SHALL be 1 exactly when k<count.
REQ-011 dispatchPacket_o lane k SHALL read entry headPtr+k mod DEPTH combinationally.
REQ-012 Data on invalid dispatch lanes is don't-care; it SHALL NOT affect branchCount_o.
REQ-013 A dispatch SHALL occur when stall_i=0 and dispatchVector_o is nonzero; nRd is the popcount of dispatchVector_o, and headPtr advances by nRd.
REQ-014 If stall_i=1 then nRd=0, and the outputs SHALL hold their values while the head is unchanged.
REQ-015 Next count SHALL be count+nWr-nRd, computed at CNT_W+1 bits; count never exceeds DEPTH and never underflows.
REQ-016 A simultaneous write and dispatch SHALL both take effect in the same cycle.
REQ-017 The dispatched entries SHALL be the old head entries; a same-cycle write never bypasses to the dispatch outputs.
REQ-018 count_o SHALL equal the count register.
REQ-019 A full queue (count=DEPTH) SHALL still dispatch normally.
REQ-020 An empty queue (count=0) SHALL drive dispatchVector_o=0 and branchCount_o=0 in both modes.
REQ-021 Write and read addresses SHALL wrap from DEPTH-1 to 0 with no gaps or corruption.
REQ-022 flush_i=1 SHALL clear headPtr, tailPtr and count at the next edge.
REQ-023 During a flush cycle, no write is performed and no dispatch is counted.
REQ-024 Stored entry data need not be cleared by flush or reset.
REQ-025 partialEn_i MAY change on any cycle; it SHALL take effect combinationally on dispatchVector_o in that cycle.

Reset
REQ-026 reset=1 SHALL clear headPtr, tailPtr and count to 0 immediately, without waiting for clk.
REQ-027 Held reset SHALL force these outputs: stallFetch_o=0, dispatchVector_o=0, branchCount_o=0, count_o=0.
REQ-028 Reset SHALL take priority over flush_i, writes and dispatch.
REQ-029 Deassertion SHALL be followed by normal operation on the first subsequent rising edge.
REQ-030 Reset asserted mid-burst SHALL discard all queued entries; no partial group is dispatched afterward.

Verification
REQ-031 A bench SHALL cover these directed scenarios (defaults DEPTH=32, FETCH_W=8, DISPATCH_W=4).
- Sparse write: vector 8'b1010_0101, packets tagged with lane IDs 0..7, stall_i=1 -> count_o=4; head entries hold lanes 0,2,5,7 in order.
- Full-only vs partial: count=3 with partialEn_i=0 -> dispatchVector_o=0000. Switch to partialEn_i=1 -> 0111; with stall_i=0, count_o=0 next cycle.
- Fill/stall boundary: write 8 per cycle with stall_i=1 -> count reaches 24 then 32. stallFetch_o=1 while count=32 (32>24); a further group is dropped and count stays 32.
- Wrap-around: stream 100 writes and dispatches with tags -> output tags match input order exactly across several wraps; branchCount_o matches the number of tagged branches per group.
- Flush: count=17, flush_i=1 together with decodeReady_i=1 -> next cycle count_o=0, dispatchVector_o=0, tailPtr=0; the next write lands at entry 0.
- Async reset: assert reset between edges with count=12 -> count_o=0 before the next edge; first group after deassertion dispatches correctly.
